// File: rtl/blackjack_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : blackjack_input_conditioner
// Purpose  : Board-level front end for the blackjack game core. It
//            synchronises, debounces and edge-detects the raw Basys 3
//            buttons and switches. It produces one-hot, single-cycle action
//            pulses and clean split/bet levels.
// Ports    : clk, reset (sync, active-high)
//            btn_next/hit/stand/double, sw_split, sw_bet[3:0] - raw inputs
//            round_done   - game core Win|Lose|Draw level (bet lock only)
//            next/hit/stand/double_pulse - one pulse per accepted press
//            split_level  - debounced split switch
//            bet_value    - debounced (or locked) bet, 0..15
//            bet_valid    - bet_value != 0
//            bet_locked   - bet frozen for the current round
// Options  : `define BET_LOCK_EN to freeze the bet from a "next" press until
//            round_done. Without it, bet_locked is 0 and round_done is
//            ignored.
// Revision : 1.0 - initial release
// ============================================================================
module blackjack_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       btn_hit,
    input  logic       btn_stand,
    input  logic       btn_double,
    input  logic       sw_split,
    input  logic [3:0] sw_bet,
    input  logic       round_done,
    output logic       next_pulse,
    output logic       hit_pulse,
    output logic       stand_pulse,
    output logic       double_pulse,
    output logic       split_level,
    output logic [3:0] bet_value,
    output logic       bet_valid,
    output logic       bet_locked
);

    localparam int                 c_NUM_CH   = 9;
    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel map: 0 next, 1 hit, 2 stand, 3 double, 4 split, 8:5 bet
    logic [c_NUM_CH-1:0] w_raw;
    logic [c_NUM_CH-1:0] w_stable;

    assign w_raw = {sw_bet, sw_split, btn_double, btn_stand, btn_hit, btn_next};

    for (genvar g = 0; g < c_NUM_CH; g++) begin : g_chan
        logic [SYNC_STAGES-1:0] r_sync;
        logic [c_CNT_W-1:0]     r_cnt;
        logic                   r_stable;

        // The counter only runs while the synced level disagrees with the
        // accepted level. The D-th consecutive disagreeing cycle commits the
        // change, so the counter never exceeds DEBOUNCE_CYCLES-1.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync   <= '0;
                r_cnt    <= '0;
                r_stable <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
                if (r_sync[SYNC_STAGES-1] == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    r_stable <= r_sync[SYNC_STAGES-1];
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_stable[g] = r_stable;
    end

    // ------------------------------------------------------------------
    // Button rise detect and fixed-priority arbitration.
    // A losing rise is simply dropped. Because a rise is only one cycle
    // wide, the loser cannot fire again until it is released and pressed
    // again.
    // ------------------------------------------------------------------
    logic [3:0] r_btn_d;
    logic [3:0] w_rise;
    logic [3:0] w_grant;
    logic [3:0] r_pulse;   // {double, stand, hit, next}

    assign w_rise = w_stable[3:0] & ~r_btn_d;

    always_comb begin
        w_grant = 4'b0000;
        if (w_rise[0])      w_grant[0] = 1'b1;   // next
        else if (w_rise[2]) w_grant[2] = 1'b1;   // stand
        else if (w_rise[3]) w_grant[3] = 1'b1;   // double
        else if (w_rise[1]) w_grant[1] = 1'b1;   // hit
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_d <= 4'b0000;
            r_pulse <= 4'b0000;
        end else begin
            r_btn_d <= w_stable[3:0];
            r_pulse <= w_grant;
        end
    end

    assign next_pulse   = r_pulse[0];
    assign hit_pulse    = r_pulse[1];
    assign stand_pulse  = r_pulse[2];
    assign double_pulse = r_pulse[3];
    assign split_level  = w_stable[4];

    logic [3:0] w_bet_live;
    assign w_bet_live = w_stable[8:5];

`ifdef BET_LOCK_EN
    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t r_state;
    lock_state_t w_state_nxt;
    logic [3:0]  r_bet_hold;
    logic [3:0]  w_bet_hold_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_UNLOCKED;
            r_bet_hold <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_bet_hold <= w_bet_hold_nxt;
        end
    end

    // The bet is captured in the pulse cycle, so the locked value is the
    // value the player saw when pressing "next".
    always_comb begin
        w_state_nxt    = r_state;
        w_bet_hold_nxt = r_bet_hold;
        case (r_state)
            ST_UNLOCKED: begin
                if (r_pulse[0] && (w_bet_live != 4'd0) && !round_done) begin
                    w_state_nxt    = ST_LOCKED;
                    w_bet_hold_nxt = w_bet_live;
                end
            end
            ST_LOCKED: begin
                if (round_done) begin
                    w_state_nxt = ST_UNLOCKED;
                end
            end
            default: w_state_nxt = ST_UNLOCKED;
        endcase
    end

    assign bet_locked = (r_state == ST_LOCKED);
    assign bet_value  = (r_state == ST_LOCKED) ? r_bet_hold : w_bet_live;
`else
    logic w_unused_round_done;
    assign w_unused_round_done = round_done;

    assign bet_locked = 1'b0;
    assign bet_value  = w_bet_live;
`endif

    assign bet_valid = (bet_value != 4'd0);

endmodule
`default_nettype wire

// File: tb/tb_blackjack_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_blackjack_input_conditioner
// Purpose  : Self-checking bench for blackjack_input_conditioner
//            (DEBOUNCE_CYCLES=4, SYNC_STAGES=2). Expected pulses are queued
//            with their due cycle when a press is driven. They are popped as
//            pulses appear, and any pulse with no queued entry is an error.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blackjack_input_conditioner;

    localparam int c_DEB  = 4;
    localparam int c_SYNC = 2;
    localparam int c_LAT  = c_SYNC + c_DEB + 1;   // raw press to pulse
    localparam int c_LVL  = c_SYNC + c_DEB;       // raw change to level

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_next, btn_hit, btn_stand, btn_double, sw_split;
    logic [3:0] sw_bet;
    logic       round_done;
    logic       next_pulse, hit_pulse, stand_pulse, double_pulse;
    logic       split_level, bet_valid, bet_locked;
    logic [3:0] bet_value;

    blackjack_input_conditioner #(
        .DEBOUNCE_CYCLES (c_DEB),
        .SYNC_STAGES     (c_SYNC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_next     (btn_next),
        .btn_hit      (btn_hit),
        .btn_stand    (btn_stand),
        .btn_double   (btn_double),
        .sw_split     (sw_split),
        .sw_bet       (sw_bet),
        .round_done   (round_done),
        .next_pulse   (next_pulse),
        .hit_pulse    (hit_pulse),
        .stand_pulse  (stand_pulse),
        .double_pulse (double_pulse),
        .split_level  (split_level),
        .bet_value    (bet_value),
        .bet_valid    (bet_valid),
        .bet_locked   (bet_locked)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int         due;
        logic [3:0] p;      // {double, stand, hit, next}
    } exp_t;

    exp_t q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_pulse(input logic [3:0] p);
        exp_t e;
        e.due = cyc + c_LAT;
        e.p   = p;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled just after each active edge.
    always @(posedge clk) begin
        logic [3:0] p;
        exp_t       e;
        #1;
        p = {double_pulse, stand_pulse, hit_pulse, next_pulse};
        if (p != 4'b0000) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", {28'd0, p}, 32'd0);
            end else begin
                e = q.pop_front();
                check("pulse_kind", {28'd0, p}, {28'd0, e.p});
                check("pulse_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        btn_next   = 1'b0;
        btn_hit    = 1'b0;
        btn_stand  = 1'b0;
        btn_double = 1'b0;
        sw_split   = 1'b0;
        sw_bet     = 4'd0;
        round_done = 1'b0;
        idle(3);
        check("reset_outputs",
              {20'd0, next_pulse, hit_pulse, stand_pulse, double_pulse,
               split_level, bet_value, bet_valid, bet_locked}, 32'd0);
        reset = 1'b0;
        idle(4);

        // 1: held hit -> exactly one pulse, nothing on release
        btn_hit = 1'b1;
        expect_pulse(4'b0010);
        idle(20);
        btn_hit = 1'b0;
        idle(12);
        check("t1_queue_empty", q.size(), 0);

        // 2: 3-cycle glitch rejected, then a proper press accepted
        btn_stand = 1'b1;
        idle(3);
        btn_stand = 1'b0;
        idle(10);
        check("t2_glitch_queue", q.size(), 0);
        btn_stand = 1'b1;
        expect_pulse(4'b0100);
        idle(8);
        btn_stand = 1'b0;
        idle(12);
        check("t2_queue_empty", q.size(), 0);

        // 3: next beats hit, hit only pulses after a re-press
        btn_next = 1'b1;
        btn_hit  = 1'b1;
        expect_pulse(4'b0001);
        idle(10);
        btn_next = 1'b0;
        btn_hit  = 1'b0;
        idle(12);
        btn_hit = 1'b1;
        expect_pulse(4'b0010);
        idle(10);
        btn_hit = 1'b0;
        idle(12);
        check("t3_queue_empty", q.size(), 0);

        // 4: bet and split level latency
        sw_bet   = 4'b1010;
        sw_split = 1'b1;
        repeat (c_LVL - 1) @(posedge clk);
        #1;
        check("t4_bet_early", bet_value, 0);
        check("t4_valid_early", bet_valid, 0);
        @(posedge clk);
        #1;
        check("t4_bet_value", bet_value, 10);
        check("t4_bet_valid", bet_valid, 1);
        check("t4_split_level", split_level, 1);
        check("t4_bet_locked", bet_locked, 0);
        @(negedge clk);
        sw_bet   = 4'd0;
        sw_split = 1'b0;
        repeat (c_LVL - 1) @(posedge clk);
        #1;
        check("t4_valid_hold", bet_valid, 1);
        @(posedge clk);
        #1;
        check("t4_valid_clear", bet_valid, 0);
        check("t4_bet_zero", bet_value, 0);
        check("t4_split_clear", split_level, 0);
        @(negedge clk);
        idle(4);

        // 5: reset lands on the third debounce count of a held double
        btn_double = 1'b1;
        idle(5);
        reset = 1'b1;
        idle(2);
        check("t5_reset_outputs",
              {20'd0, next_pulse, hit_pulse, stand_pulse, double_pulse,
               split_level, bet_value, bet_valid, bet_locked}, 32'd0);
        check("t5_no_pulse_yet", q.size(), 0);
        reset = 1'b0;
        expect_pulse(4'b1000);
        idle(12);
        btn_double = 1'b0;
        idle(12);
        check("t5_queue_empty", q.size(), 0);

`ifdef BET_LOCK_EN
        // 6: bet lock on next press, released by round_done
        sw_bet = 4'd5;
        idle(8);
        btn_next = 1'b1;
        expect_pulse(4'b0001);
        idle(c_LAT + 1);
        check("t6_locked", bet_locked, 1);
        check("t6_bet_at_lock", bet_value, 5);
        btn_next = 1'b0;
        sw_bet   = 4'd9;
        idle(10);
        check("t6_bet_held", bet_value, 5);
        check("t6_still_locked", bet_locked, 1);
        round_done = 1'b1;
        @(posedge clk);
        #1;
        check("t6_unlocked", bet_locked, 0);
        check("t6_bet_tracks", bet_value, 9);
        @(negedge clk);
        round_done = 1'b0;
        idle(12);
        check("t6_queue_empty", q.size(), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
